if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. Holds the PC register, sequences one-outstanding-request fetches to instruction memory, and owns the IF/ID pipeline register. Consumes `PCNext_i` from the next-PC mux and returns `PCPlus4F_o` to it. Honours stall and flush requests from the hazard unit and discards in-flight fetches on a taken branch or jump.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 56 +++++
 rtl/if_stage.sv | 158 +++++++++++++++
 tb/tb_if_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline front end.
//   NOP_INSTR        : canonical bubble encoding (addi x0, x0, 0)
//   RESET_PC_DEFAULT : default PC loaded on reset
//   fetch_state_t    : instruction-fetch sequencer states
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // REQ : no fetch outstanding, a request goes out at PCF
  // WAIT: one fetch outstanding, its address is PCF
  // HOLD: word returned while stalled, parked in the hold register
  // DROP: outstanding fetch belongs to a redirected path, discard it
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk_i, rst_i            : clock, async active-high reset
//   flush_i                 : load a bubble (highest priority)
//   stall_i                 : hold current contents
//   load_i                  : capture {instr_i, pc_i, pc_plus4_i} as valid
//   instr_o/pc_o/pc_plus4_o : register contents
//   valid_o                 : register holds a real instruction
// With none of flush/stall/load a bubble is loaded.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_o    <= NOP;
      pc_o       <= '0;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
    end else if (flush_i) begin
      instr_o    <= NOP;
      pc_o       <= '0;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
    end else if (stall_i) begin
      // hold
    end else if (load_i) begin
      instr_o    <= instr_i;
      pc_o       <= pc_i;
      pc_plus4_o <= pc_plus4_i;
      valid_o    <= 1'b1;
    end else begin
      instr_o    <= NOP;
      pc_o       <= '0;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch
// sequencer, hold register and the IF/ID pipeline register.
//   clk_i, rst_i                   : clock, async active-high reset
//   PCNext_i                       : next PC from the next-PC mux
//   PCSrcE_i                       : taken branch/jump in EX
//   StallF_i, StallD_i, FlushD_i   : hazard unit controls
//   IMemReq_o, IMemAddr_o          : fetch request (accepted same cycle)
//   IMemRspValid_i, IMemRdata_i    : fetch response, >=1 cycle later
//   PCF_o, PCPlus4F_o              : current PC and PC+4 (to next-PC mux)
//   InstrD_o, PCD_o, PCPlus4D_o    : IF/ID contents
//   ValidD_o                       : IF/ID holds a real instruction
//   FetchBusy_o                    : no instruction delivered this cycle
module if_stage
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] PCNext_i,
  input  logic                  PCSrcE_i,
  input  logic                  StallF_i,
  input  logic                  StallD_i,
  input  logic                  FlushD_i,
  output logic                  IMemReq_o,
  output logic [DATA_WIDTH-1:0] IMemAddr_o,
  input  logic                  IMemRspValid_i,
  input  logic [DATA_WIDTH-1:0] IMemRdata_i,
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic [DATA_WIDTH-1:0] PCPlus4F_o,
  output logic [DATA_WIDTH-1:0] InstrD_o,
  output logic [DATA_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] PCPlus4D_o,
  output logic                  ValidD_o,
  output logic                  FetchBusy_o
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] addr;
  logic                  req;
  logic                  deliver;
  logic                  stall;

  assign stall = StallF_i | StallD_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    req     = 1'b0;
    addr    = pc_q;
    word    = hold_q;
    deliver = 1'b0;
    case (state_q)
      REQ: begin
        // any response seen here is a protocol error or stale; ignored
        if (PCSrcE_i) begin
          pc_d = PCNext_i;
        end else begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (IMemRspValid_i) begin
          word = IMemRdata_i;
          if (PCSrcE_i) begin
            // redirect beats the returning word
            pc_d = PCNext_i;
            req  = 1'b1;
            addr = PCNext_i;
          end else if (stall) begin
            hold_d  = IMemRdata_i;
            state_d = HOLD;
          end else begin
            deliver = 1'b1;
          end
        end else if (PCSrcE_i) begin
          pc_d    = PCNext_i;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (PCSrcE_i) begin
          pc_d    = PCNext_i;
          req     = 1'b1;
          addr    = PCNext_i;
          state_d = WAIT;
        end else if (!stall) begin
          deliver = 1'b1;
        end
      end
      DROP: begin
        if (IMemRspValid_i) begin
          // wrong-path word retired; refetch at the redirected PC,
          // which may itself be moving this cycle
          req     = 1'b1;
          state_d = WAIT;
          if (PCSrcE_i) begin
            pc_d = PCNext_i;
            addr = PCNext_i;
          end
        end else if (PCSrcE_i) begin
          pc_d = PCNext_i;
        end
      end
      default: state_d = REQ;
    endcase
    // delivery always advances the PC and chains the next fetch
    if (deliver) begin
      pc_d    = PCNext_i;
      req     = 1'b1;
      addr    = PCNext_i;
      state_d = WAIT;
    end
  end

  // state reads REQ during reset; keep the memory port quiet
  assign IMemReq_o   = req & ~rst_i;
  assign IMemAddr_o  = addr;
  assign PCF_o       = pc_q;
  assign PCPlus4F_o  = pc_q + DATA_WIDTH'(4);
  assign FetchBusy_o = ~deliver;

  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (FlushD_i),
    .stall_i    (StallD_i),
    .load_i     (deliver),
    .instr_i    (word),
    .pc_i       (pc_q),
    .pc_plus4_i (PCPlus4F_o),
    .instr_o    (InstrD_o),
    .pc_o       (PCD_o),
    .pc_plus4_o (PCPlus4D_o),
    .valid_o    (ValidD_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory model returning addr^A5A5_0000 after a
// programmable latency, scoreboard of expected IF/ID loads (by PC).
module tb_if_stage;
  import riscv_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] XORK = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic         redir_en = 1'b0;
  logic [W-1:0] redir_pc = '0;
  logic         rsp_v = 1'b0;
  logic [W-1:0] rdata = '0;
  logic         PCSrcE;
  logic [W-1:0] PCNext;
  logic         IMemReq, ValidD, FetchBusy;
  logic [W-1:0] IMemAddr, PCF, PCPlus4F, InstrD, PCD, PCPlus4D;

  assign PCSrcE = redir_en;
  assign PCNext = redir_en ? redir_pc : PCPlus4F;

  if_stage #(.DATA_WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .PCNext_i(PCNext), .PCSrcE_i(PCSrcE),
    .StallF_i(StallF), .StallD_i(StallD), .FlushD_i(FlushD),
    .IMemReq_o(IMemReq), .IMemAddr_o(IMemAddr),
    .IMemRspValid_i(rsp_v), .IMemRdata_i(rdata),
    .PCF_o(PCF), .PCPlus4F_o(PCPlus4F), .InstrD_o(InstrD), .PCD_o(PCD),
    .PCPlus4D_o(PCPlus4D), .ValidD_o(ValidD), .FetchBusy_o(FetchBusy)
  );

  // memory model
  int           lat = 1;
  bit           keep_stale = 1'b0;
  bit           busy = 1'b0;
  int           cnt = 0;
  logic [W-1:0] paddr = '0;
  logic         req_s = 1'b0;
  logic [W-1:0] addr_s = '0;

  always @(negedge clk) begin
    req_s  = IMemReq;
    addr_s = IMemAddr;
  end

  always @(posedge clk) begin
    #1;
    rsp_v = 1'b0;
    if (rst && !keep_stale) begin
      busy = 1'b0;
    end else begin
      if (req_s) begin
        busy  = 1'b1;
        cnt   = lat;
        paddr = addr_s;
      end
      if (busy) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          rsp_v = 1'b1;
          rdata = paddr ^ XORK;
          busy  = 1'b0;
        end
      end
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  logic         stalld_prev = 1'b0;
  logic [W-1:0] exp_pc;

  // a valid IF/ID entry that was not held by StallD is a fresh load
  task sb_check();
    if (!rst && ValidD && !stalld_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no delivery", PCD, InstrD);
      end else begin
        exp_pc = exp_q.pop_front();
        if (PCD !== exp_pc || InstrD !== (exp_pc ^ XORK) || PCPlus4D !== exp_pc + 32'd4) begin
          bad++;
          $display("FAIL sb_entry: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                   PCD, InstrD, PCPlus4D, exp_pc, exp_pc ^ XORK, exp_pc + 32'd4);
        end
      end
    end
  endtask

  task half();
    @(negedge clk);
    sb_check();
  endtask

  task adv();
    @(posedge clk);
    stalld_prev = StallD;
    #1;
  endtask

  // leaves the bench 1ns after an edge, first cycle out of reset
  task reset_dut();
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    redir_en = 1'b0; redir_pc = '0;
    exp_q.delete();
    adv(); half();
    adv(); half();
    adv();
    rst = 1'b0;
  endtask

  task stop_chk(input string name);
    adv();
    StallF = 1'b1; StallD = 1'b1;
    half();
    adv(); half();
    rst = 1'b1;
    adv(); half();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: got %0d undelivered, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task test_reset();
    rst = 1'b1;
    adv(); half();
    total++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", IMemReq); end
    total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ValidD); end
    total++; if (InstrD !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr: got %h want 00000013", InstrD); end
    total++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin bad++; $display("FAIL rst_pcd: got %h/%h want 0/0", PCD, PCPlus4D); end
    total++; if (PCF !== 32'h0) begin bad++; $display("FAIL rst_pcf: got %h want 0", PCF); end
    total++; if (dut.state_q !== REQ) begin bad++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, REQ); end
  endtask

  task test_sequential();
    lat = 1;
    reset_dut();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    half();
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin bad++; $display("FAIL seq_req0: got %b/%h want 1/0", IMemReq, IMemAddr); end
    adv(); half();
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin bad++; $display("FAIL seq_req4: got %b/%h want 1/4", IMemReq, IMemAddr); end
    total++; if (FetchBusy !== 1'b0) begin bad++; $display("FAIL seq_busy: got %b want 0", FetchBusy); end
    adv(); half();
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin bad++; $display("FAIL seq_req8: got %b/%h want 1/8", IMemReq, IMemAddr); end
    total++; if (ValidD !== 1'b1 || InstrD !== 32'hA5A5_0000 || PCD !== 32'h0) begin
      bad++; $display("FAIL seq_first: got %b/%h/%h want 1/a5a50000/0", ValidD, InstrD, PCD);
    end
    stop_chk("seq");
  endtask

  task test_stall();
    lat = 1;
    reset_dut();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    half();
    adv(); half();
    adv();
    StallF = 1'b1; StallD = 1'b1;
    half();
    total++; if (IMemReq !== 1'b0 || FetchBusy !== 1'b1) begin bad++; $display("FAIL stall_noreq: got req=%b busy=%b want 0/1", IMemReq, FetchBusy); end
    for (int i = 0; i < 2; i++) begin
      adv(); half();
      total++; if (dut.state_q !== HOLD) begin bad++; $display("FAIL stall_hold: got %0d want %0d", dut.state_q, HOLD); end
      total++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", IMemReq); end
      total++; if (InstrD !== 32'hA5A5_0000 || PCD !== 32'h0 || ValidD !== 1'b1) begin
        bad++; $display("FAIL stall_ifid: got %h/%h/%b want a5a50000/0/1", InstrD, PCD, ValidD);
      end
    end
    adv();
    StallF = 1'b0; StallD = 1'b0;
    half();
    total++; if (FetchBusy !== 1'b0) begin bad++; $display("FAIL stall_release: got busy=%b want 0", FetchBusy); end
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin bad++; $display("FAIL stall_nextreq: got %b/%h want 1/8", IMemReq, IMemAddr); end
    adv(); half();
    total++; if (PCD !== 32'h4 || ValidD !== 1'b1) begin bad++; $display("FAIL stall_held_pc: got %h/%b want 4/1", PCD, ValidD); end
    stop_chk("stall");
  endtask

  task test_drop();
    lat = 3;
    reset_dut();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h100);
    half();
    adv(); half();
    adv(); half();
    adv(); half();
    total++; if (FetchBusy !== 1'b0 || IMemAddr !== 32'h4) begin bad++; $display("FAIL drop_c3: got busy=%b addr=%h want 0/4", FetchBusy, IMemAddr); end
    adv(); half();
    adv(); half();
    adv(); half();
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin bad++; $display("FAIL drop_req8: got %b/%h want 1/8", IMemReq, IMemAddr); end
    adv();
    redir_en = 1'b1; redir_pc = 32'h100;
    half();
    total++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL drop_noreq: got %b want 0", IMemReq); end
    adv();
    redir_en = 1'b0;
    half();
    total++; if (dut.state_q !== DROP) begin bad++; $display("FAIL drop_state: got %0d want %0d", dut.state_q, DROP); end
    total++; if (PCF !== 32'h100 || IMemReq !== 1'b0) begin bad++; $display("FAIL drop_pcf: got %h/%b want 100/0", PCF, IMemReq); end
    adv(); half();
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h100) begin bad++; $display("FAIL drop_refetch: got %b/%h want 1/100", IMemReq, IMemAddr); end
    total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL drop_bubble: got %b want 0", ValidD); end
    adv(); half();
    adv(); half();
    adv(); half();
    total++; if (FetchBusy !== 1'b0) begin bad++; $display("FAIL drop_deliver: got busy=%b want 0", FetchBusy); end
    stop_chk("drop");
    lat = 1;
  endtask

  task test_redirect_rsp();
    lat = 1;
    reset_dut();
    exp_q.push_back(32'h0); exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    half();
    adv(); half();
    adv();
    redir_en = 1'b1; redir_pc = 32'h40;
    half();
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h40) begin bad++; $display("FAIL redir_req: got %b/%h want 1/40", IMemReq, IMemAddr); end
    total++; if (FetchBusy !== 1'b1) begin bad++; $display("FAIL redir_discard: got busy=%b want 1", FetchBusy); end
    adv();
    redir_en = 1'b0;
    half();
    total++; if (PCF !== 32'h40 || FetchBusy !== 1'b0 || IMemAddr !== 32'h44) begin
      bad++; $display("FAIL redir_next: got pcf=%h busy=%b addr=%h want 40/0/44", PCF, FetchBusy, IMemAddr);
    end
    adv(); half();
    total++; if (PCD !== 32'h40 || ValidD !== 1'b1) begin bad++; $display("FAIL redir_ifid: got %h/%b want 40/1", PCD, ValidD); end
    stop_chk("redir");
  endtask

  task test_flush();
    lat = 1;
    reset_dut();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    half();
    adv(); half();
    adv();
    FlushD = 1'b1; StallD = 1'b1;
    half();
    total++; if (ValidD !== 1'b1 || PCD !== 32'h0) begin bad++; $display("FAIL flush_pre: got %b/%h want 1/0", ValidD, PCD); end
    adv();
    FlushD = 1'b0; StallD = 1'b0;
    half();
    total++; if (ValidD !== 1'b0 || InstrD !== 32'h0000_0013) begin bad++; $display("FAIL flush_ifid: got %b/%h want 0/00000013", ValidD, InstrD); end
    total++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin bad++; $display("FAIL flush_pcd: got %h/%h want 0/0", PCD, PCPlus4D); end
    total++; if (FetchBusy !== 1'b0 || IMemAddr !== 32'h8) begin bad++; $display("FAIL flush_held: got busy=%b addr=%h want 0/8", FetchBusy, IMemAddr); end
    adv(); half();
    total++; if (PCD !== 32'h4 || ValidD !== 1'b1) begin bad++; $display("FAIL flush_after: got %h/%b want 4/1", PCD, ValidD); end
    stop_chk("flush");
  endtask

  task test_wrap();
    lat = 1;
    reset_dut();
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    redir_en = 1'b1; redir_pc = 32'hFFFF_FFFC;
    half();
    total++; if (IMemReq !== 1'b0) begin bad++; $display("FAIL wrap_req_redir: got %b want 0", IMemReq); end
    adv();
    redir_en = 1'b0;
    half();
    total++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h/%h want fffffffc/0", PCF, PCPlus4F); end
    total++; if (IMemReq !== 1'b1 || IMemAddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", IMemReq, IMemAddr); end
    adv(); half();
    total++; if (FetchBusy !== 1'b0 || IMemAddr !== 32'h0) begin bad++; $display("FAIL wrap_next: got busy=%b addr=%h want 0/0", FetchBusy, IMemAddr); end
    adv(); half();
    total++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin bad++; $display("FAIL wrap_ifid: got %h/%h want fffffffc/0", PCD, PCPlus4D); end
    stop_chk("wrap");
  endtask

  task test_reset_mid();
    lat = 3;
    reset_dut();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    half();
    for (int i = 0; i < 4; i++) begin
      adv(); half();
    end
    adv();
    keep_stale = 1'b1; rst = 1'b1;
    half();
    total++; if (PCF !== 32'h0 || IMemReq !== 1'b0 || ValidD !== 1'b0) begin
      bad++; $display("FAIL rmid_clear: got pcf=%h req=%b valid=%b want 0/0/0", PCF, IMemReq, ValidD);
    end
    adv();
    rst = 1'b0;
    half();
    total++; if (dut.state_q !== REQ || IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
      bad++; $display("FAIL rmid_fresh: got state=%0d req=%b addr=%h want %0d/1/0", dut.state_q, IMemReq, IMemAddr, REQ);
    end
    total++; if (FetchBusy !== 1'b1) begin bad++; $display("FAIL rmid_stale: got busy=%b want 1", FetchBusy); end
    for (int i = 0; i < 3; i++) begin
      adv(); half();
    end
    total++; if (FetchBusy !== 1'b0) begin bad++; $display("FAIL rmid_deliver: got busy=%b want 0", FetchBusy); end
    adv(); half();
    total++; if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== 32'hA5A5_0000) begin
      bad++; $display("FAIL rmid_ifid: got %b/%h/%h want 1/0/a5a50000", ValidD, PCD, InstrD);
    end
    keep_stale = 1'b0;
    stop_chk("rmid");
    lat = 1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_drop();
    test_redirect_rsp();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
